// File: rtl/lane_scroll_scheduler.sv
// Per-frame lane scroll scheduler: once per vertical blank it walks every lane
// and advances its horizontal scroll offset by its configured speed/direction.
// Optional build macro: LANE_SYNC_EN adds sync_lanes to re-align all lanes.
module lane_scroll_scheduler #(
    parameter int unsigned NUM_LANES   = 12,
    parameter int unsigned PLAYFIELD_W = 448,
    parameter int unsigned FRAME_ROW   = 480,
    parameter int unsigned PERIOD_W    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                on,
    input  logic [9:0]          colPos,
    input  logic [9:0]          rowPos,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_lane,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_dir,
    input  logic [3:0]          rd_lane,
`ifdef LANE_SYNC_EN
    input  logic                sync_lanes,
`endif
    output logic [8:0]          lane_offset,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned OFF_W  = 9;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned POS_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [LANE_W-1:0]   idx;
    logic                cond_q;
    logic                cond_c;
    logic                start_c;
    logic                sync_apply_c;

    logic [OFF_W-1:0]    offset [NUM_LANES];
    logic [PERIOD_W-1:0] cnt    [NUM_LANES];
    logic [PERIOD_W-1:0] period [NUM_LANES];
    logic                dir    [NUM_LANES];

    // One pixel step with wrap inside 0..PLAYFIELD_W-1; d=1 moves left
    function automatic logic [OFF_W-1:0] step_off(input logic [OFF_W-1:0] o, input logic d);
        if (d) begin
            step_off = (o == '0) ? OFF_W'(PLAYFIELD_W - 1) : o - OFF_W'(1);
        end else begin
            step_off = (o == OFF_W'(PLAYFIELD_W - 1)) ? '0 : o + OFF_W'(1);
        end
    endfunction

    // Frame start is the rising edge of the blank-start position, gated by on
    assign cond_c  = (rowPos == POS_W'(FRAME_ROW)) && (colPos == '0);
    assign start_c = cond_c && !cond_q && on;

`ifdef LANE_SYNC_EN
    logic sync_pend;
    assign sync_apply_c = (state == IDLE) && (sync_lanes || sync_pend);
`else
    assign sync_apply_c = 1'b0;
`endif

    // Registered copy of the blank-start condition for edge detection
    always_ff @(posedge clk) begin
        if (reset) cond_q <= 1'b0;
        else       cond_q <= cond_c;
    end

    // Scan sequencer with Moore-registered busy/frame_done
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start_c) begin
                        state <= SCAN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (idx == LANE_W'(NUM_LANES - 1)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        idx <= idx + LANE_W'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef LANE_SYNC_EN
    // Hold a sync request that arrives mid-scan until the scheduler is idle
    always_ff @(posedge clk) begin
        if (reset)                           sync_pend <= 1'b0;
        else if (state == IDLE)              sync_pend <= 1'b0;
        else if (sync_lanes)                 sync_pend <= 1'b1;
    end
`endif

    // Per-lane config, frame advance and sync clearing; a config write beats the scan step
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                offset[i] <= '0;
                cnt[i]    <= '0;
                period[i] <= '0;
                dir[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (cfg_we && (cfg_lane == LANE_W'(i))) begin
                    period[i] <= cfg_period;
                    dir[i]    <= cfg_dir;
                    cnt[i]    <= '0;
                end else if ((state == SCAN) && (idx == LANE_W'(i)) && (period[i] != '0)) begin
                    if (cnt[i] == '0) begin
                        cnt[i]    <= period[i] - PERIOD_W'(1);
                        offset[i] <= step_off(offset[i], dir[i]);
                    end else begin
                        cnt[i] <= cnt[i] - PERIOD_W'(1);
                    end
                end
                if (sync_apply_c) begin
                    offset[i] <= '0;
                    cnt[i]    <= '0;
                end
            end
        end
    end

    // Registered read port; out-of-range lanes read as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_offset <= '0;
        end else if ((5'(rd_lane)) < 5'(NUM_LANES)) begin
            lane_offset <= offset[rd_lane];
        end else begin
            lane_offset <= '0;
        end
    end

endmodule

// File: doc/lane_scroll_scheduler.md
Name: lane_scroll_scheduler

Overview:
Per-frame scheduler for the playfield renderer. It holds a horizontal scroll offset for each lane: river rows 1-6 and road rows 8-13. Once per frame, during vertical blank, it walks all lanes and advances each offset according to a per-lane speed and direction. Renderers read offsets through a registered read port to shift log/car patterns across the 448-pixel playfield (columns 96..543).

Parameters:
NUM_LANES, 12, number of scrolling lanes (index 0..NUM_LANES-1)
PLAYFIELD_W, 448, offset modulus in pixels
FRAME_ROW, 480, rowPos value marking start of vertical blank
PERIOD_W, 6, width of per-lane period and frame counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
on  input  1  game running; when 0, frame starts are ignored
colPos  input  10  current scan column
rowPos  input  10  current scan row
cfg_we  input  1  lane config write strobe
cfg_lane  input  4  lane index for config write
cfg_period  input  PERIOD_W  frames per 1-px step; 0 = lane stopped
cfg_dir  input  1  0 = move right (+1), 1 = move left (-1)
rd_lane  input  4  lane index to read
lane_offset  output  9  offset of rd_lane, 0..PLAYFIELD_W-1
busy  output  1  high while state is SCAN
frame_done  output  1  one-cycle pulse after all lanes are processed

Behaviour:
- Reset (sync, active-high) has priority over all other activity, including mid-SCAN.
  - State -> IDLE; all offsets, counters, periods and dirs -> 0.
  - lane_offset = 0, busy = 0, frame_done = 0.
- Frame-start detect:
  - cond = (rowPos == FRAME_ROW) && (colPos == 0); cond_q is cond registered.
  - start = cond && !cond_q && on. Rising edge only, so a cond held for several clocks gives exactly one start.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: on start, go to SCAN with idx = 0.
  - SCAN: one lane per cycle. Stay while idx < NUM_LANES-1 (idx += 1); at idx == NUM_LANES-1, go to DONE.
  - DONE: frame_done = 1 for exactly this cycle, then IDLE. Outputs are Moore.
- Timing: if start is true in cycle T, SCAN occupies cycles T+1..T+NUM_LANES and frame_done is high in cycle T+NUM_LANES+1.
- start while in SCAN or DONE: ignored, no queuing.
- Lane update in SCAN for lane idx, registered at end of cycle:
  - period == 0: no change.
  - cnt == 0: cnt <= period-1; offset steps by ±1 per dir.
  - otherwise: cnt <= cnt-1.
  - Net effect: a lane with period P moves 1 px every P frames, first step on the first frame after config.
- Wrap rules:
  - Right step: offset == PLAYFIELD_W-1 -> 0, else +1.
  - Left step: offset == 0 -> PLAYFIELD_W-1, else -1.
  - Offset never leaves 0..PLAYFIELD_W-1.
- Config write, accepted any cycle:
  - cfg_we with cfg_lane < NUM_LANES sets period/dir and clears that lane's cnt to 0; offset unchanged.
  - cfg_lane >= NUM_LANES: write dropped.
  - Write to the lane being processed in the same SCAN cycle: the write wins; period/dir/cnt take the written values and that lane's offset does not step this frame.
- Read port: lane_offset <= offset[rd_lane], 1-cycle latency. rd_lane >= NUM_LANES returns 0. A read of a lane updated in the same cycle returns the pre-update value.
- on = 0: no new scans. An in-progress scan completes. Offsets hold.

Optional Feature:
LANE_SYNC_EN.
- Defined:
  - Adds input sync_lanes (1 bit).
  - A pulse in IDLE zeroes all offsets and all cnt values in one cycle; periods and dirs are kept.
  - A pulse in SCAN or DONE is latched and applied on the first IDLE cycle.
  - Used on level restart so all lanes re-align.
- Not defined: port absent, offsets are cleared only by reset.

Test Plan:
- Reset, no config; drive rowPos=480, colPos=0 for 3 clocks -> exactly one scan. busy high for 12 cycles; frame_done one pulse at T+13; all offsets read 0.
- Lane 0: period=1, dir=0; run 448 frames -> offset 1,2,...,447, then 0 on frame 448.
- Lane 5: period=3, dir=1; run 7 frames -> offsets per frame 447,447,447,446,446,446,445.
- Write lane 3 (period=2) in the exact SCAN cycle idx=3 with offset=10 -> lane 3 offset stays 10 that frame; next frame 11.
- Assert reset mid-SCAN at idx=6 -> next cycle busy=0, no frame_done, all offsets 0. Also: cfg_lane=13 write -> no lane changes; rd_lane=13 -> 0.
- on=0 with repeated frame starts -> busy never asserts, offsets constant. With LANE_SYNC_EN: sync_lanes during SCAN -> offsets all 0 one cycle after returning to IDLE.
